wid_rr_packet_arbiter: RTL

//  Round-robin arbiter sharing one WIDTH-bit output channel between NUM_REQ packet sources.

---
 rtl/wid_arb_pkg.sv | 10 +
 rtl/wid_rr_picker.sv | 37 +++
 rtl/wid_rr_packet_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wid_arb_pkg.sv
// rtl/wid_arb_pkg.sv - shared types and pointer helper for the round-robin packet arbiter
package wid_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wid_rr_picker.sv
// rtl/wid_rr_picker.sv - combinational round-robin winner search starting at the pointer
module wid_rr_picker
  import wid_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_shift;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W:0]       w_off;
  logic [IDX_W:0]       w_sum;

  // Rotating a doubled copy puts the pointer's requester at bit 0 of w_rot.
  assign w_dbl   = {i_valid, i_valid};
  assign w_shift = w_dbl >> i_ptr;
  assign w_rot   = w_shift[NUM_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (IDX_W+1)'(k);
    end
  end

  assign w_sum = {1'b0, i_ptr} + w_off;
  assign o_idx = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                : w_sum[IDX_W-1:0];
  assign o_any = |i_valid;

endmodule

// File: rtl/wid_rr_packet_arbiter.sv
// rtl/wid_rr_packet_arbiter.sv - packet-granular round-robin arbiter onto one registered output channel
module wid_rr_packet_arbiter
  import wid_arb_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [IDX_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic                     busy
);

  generate
    if (NUM_REQ < 2 || WIDTH < 1) begin : g_param_check
      $error("wid_rr_packet_arbiter: NUM_REQ must be >= 2 and WIDTH >= 1");
    end
  endgenerate

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_last;
  logic [IDX_W-1:0]   r_out_src;

  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_can_load;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_req_ready;

  wid_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_idx == IDX_W'(i)) begin
        w_sel_data  = req_data[i*WIDTH +: WIDTH];
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
      end
    end
  end

  // The output register can take a new beat when empty or being drained this cycle.
  assign w_can_load = !r_out_valid || out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) w_state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r_grant_idx == IDX_W'(i)) w_req_ready[i] = w_can_load;
        end
        w_accept = w_sel_valid && w_can_load;
        if (w_accept && w_sel_last) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_any) begin
        r_grant_idx <= w_pick_idx;
      end
      if (w_accept && w_sel_last) begin
        r_rr_ptr <= IDX_W'(rr_next(32'(r_grant_idx), NUM_REQ));
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_last  <= w_sel_last;
        r_out_src   <= r_grant_idx;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;
  assign busy      = (r_state == ARB_GRANT);

endmodule
